if_sequencer: RTL and testbench

Execution controller for the IF stage: loads a program into instruction memory word by word. It then sequences the program counter register in continuous or single-step mode and detects the halt instruction. After halt it drains the pipeline and reports completion to the debug unit. It sits between the debug/UART unit, the hazard/branch logic and the IF datapath (PC register, PC-select mux, instruction memory).

---
 rtl/if_pkg.sv | 20 ++
 rtl/if_sequencer_edge_detect.sv | 26 ++
 rtl/if_sequencer.sv | 176 +++++++++++++++++
 tb/tb_if_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the IF-stage execution controller.
//   state_t              : controller state encoding, also driven on o_state
//   HALT_OPCODE          : instruction word that ends a program load and execution
//   DEFAULT_DRAIN_CYCLES : default pipeline drain length after halt
package if_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_RUN       = 3'd2,
        ST_STEP_WAIT = 3'd3,
        ST_STEP_EXEC = 3'd4,
        ST_DRAIN     = 3'd5,
        ST_HALTED    = 3'd6
    } state_t;

    localparam logic [31:0] HALT_OPCODE          = 32'hFC00_0000;
    localparam int unsigned DEFAULT_DRAIN_CYCLES = 4;

endpackage

// File: rtl/if_sequencer_edge_detect.sv
// Two-flop synchronizer plus rising-edge detector.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset
//   level : asynchronous level input
//   rise  : one-cycle pulse after a synchronized 0->1 transition
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic [2:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[1:0], level};
        end
    end

    // sync[1] is the synchronized level, sync[2] its previous value
    assign rise = sync[1] & ~sync[2];

endmodule

// File: rtl/if_sequencer.sv
// IF-stage execution controller: program load, continuous / single-step
// sequencing of the PC register, halt detection, pipeline drain.
//   i_clk, i_reset         : clock, asynchronous active-low reset
//   i_load_*               : program load handshake from the debug unit
//   i_run, i_mode_step     : execution start and mode select
//   i_step, i_clear        : single-step request level, return to idle
//   i_halt_signal          : fetched word is the halt opcode
//   i_stall, i_branch_*    : hazard stall and branch redirect
//   o_imem_*               : registered instruction-memory write port, fetch enable
//   o_pc_*                 : PC register / PC-select mux control (combinational)
//   o_loaded, o_done       : program resident, execution finished
//   o_state, o_cycle_count : debug readout
module if_sequencer
    import if_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned MEM_DEPTH    = 64,
    parameter int unsigned DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load_start,
    input  logic              i_load_valid,
    input  logic [31:0]       i_load_data,
    input  logic              i_run,
    input  logic              i_mode_step,
    input  logic              i_step,
    input  logic              i_clear,
    input  logic              i_halt_signal,
    input  logic              i_stall,
    input  logic              i_branch_taken,
    input  logic [ADDR_W-1:0] i_branch_target,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_waddr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_imem_valid,
    output logic              o_pc_enable,
    output logic              o_pc_halt,
    output logic              o_pc_stall,
    output logic              o_pc_clear,
    output logic              o_pc_sel,
    output logic [ADDR_W-1:0] o_pc_target,
    output logic              o_loaded,
    output logic              o_done,
    output logic [2:0]        o_state,
    output logic [31:0]       o_cycle_count
);

    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0]     DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [ADDR_W-1:0] PTR_LAST   = ADDR_W'(MEM_DEPTH - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] load_ptr;
    logic [DW-1:0]     drain_cnt;
    logic              step_rise;
    logic              load_end;

    edge_detect u_step_edge (
        .clk   (i_clk),
        .rst_n (i_reset),
        .level (i_step),
        .rise  (step_rise)
    );

    assign load_end    = i_load_valid && ((i_load_data == HALT_OPCODE) || (load_ptr == PTR_LAST));
    assign o_pc_target = i_branch_target;
    assign o_state     = state;

    // Next state and PC control; halt outranks stall, stall outranks branch
    always_comb begin
        state_next   = state;
        o_imem_valid = 1'b0;
        o_pc_enable  = 1'b0;
        o_pc_halt    = 1'b0;
        o_pc_stall   = 1'b0;
        o_pc_clear   = 1'b0;
        o_pc_sel     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (i_load_start) begin
                    state_next = ST_LOAD;
                end else if (i_run && o_loaded) begin
                    state_next = i_mode_step ? ST_STEP_WAIT : ST_RUN;
                end
            end
            ST_LOAD: begin
                if (load_end) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RUN, ST_STEP_EXEC: begin
                o_imem_valid = 1'b1;
                if (i_halt_signal) begin
                    o_pc_halt  = 1'b1;
                    state_next = ST_DRAIN;
                end else if (i_stall) begin
                    o_pc_stall = 1'b1;
                end else begin
                    o_pc_enable = 1'b1;
                    o_pc_sel    = i_branch_taken;
                    if (state == ST_STEP_EXEC) begin
                        state_next = ST_STEP_WAIT;
                    end
                end
            end
            ST_STEP_WAIT: begin
                if (step_rise) begin
                    state_next = ST_STEP_EXEC;
                end
            end
            ST_DRAIN: begin
                o_pc_halt    = 1'b1;
                o_imem_valid = 1'b1;
                if (drain_cnt == DRAIN_LAST) begin
                    state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                o_pc_halt = 1'b1;
                if (i_clear) begin
                    o_pc_clear = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state         <= ST_IDLE;
            load_ptr      <= '0;
            drain_cnt     <= '0;
            o_cycle_count <= '0;
            o_imem_we     <= 1'b0;
            o_imem_waddr  <= '0;
            o_imem_wdata  <= '0;
            o_loaded      <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            state     <= state_next;
            o_done    <= (state_next == ST_HALTED);
            o_imem_we <= 1'b0;

            if (state == ST_IDLE && i_load_start) begin
                load_ptr <= '0;
                o_loaded <= 1'b0;
            end

            if (state == ST_LOAD && i_load_valid) begin
                o_imem_we    <= 1'b1;
                o_imem_waddr <= load_ptr;
                o_imem_wdata <= i_load_data;
                load_ptr     <= load_ptr + 1'b1;
                if (load_end) begin
                    o_loaded <= 1'b1;
                end
            end

            if (state == ST_DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
            end else begin
                drain_cnt <= '0;
            end

            if (state == ST_HALTED && i_clear) begin
                o_cycle_count <= '0;
            end else if (o_pc_enable && (o_cycle_count != '1)) begin
                o_cycle_count <= o_cycle_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_sequencer.sv
// Self-checking bench for if_sequencer with a PC register / instruction
// memory model driven by the DUT's control outputs.
module tb_if_sequencer;

    localparam logic [31:0] HALT = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_load_start = 1'b0, i_load_valid = 1'b0, i_run = 1'b0, i_mode_step = 1'b0;
    logic        i_step = 1'b0, i_clear = 1'b0, i_stall = 1'b0, i_branch_taken = 1'b0;
    logic [31:0] i_load_data = '0, i_branch_target = '0;
    logic        i_halt_signal;
    logic        o_imem_we, o_imem_valid, o_pc_enable, o_pc_halt, o_pc_stall, o_pc_clear, o_pc_sel;
    logic        o_loaded, o_done;
    logic [31:0] o_imem_waddr, o_imem_wdata, o_pc_target, o_cycle_count;
    logic [2:0]  o_state;

    logic [31:0] mem [64];
    logic [31:0] pc;
    int          write_count = 0;
    int          errors = 0;
    int          checks = 0;

    if_sequencer #(.ADDR_W(32), .MEM_DEPTH(64), .DRAIN_CYCLES(4)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_load_start(i_load_start), .i_load_valid(i_load_valid),
        .i_load_data(i_load_data), .i_run(i_run), .i_mode_step(i_mode_step), .i_step(i_step),
        .i_clear(i_clear), .i_halt_signal(i_halt_signal), .i_stall(i_stall),
        .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
        .o_imem_we(o_imem_we), .o_imem_waddr(o_imem_waddr), .o_imem_wdata(o_imem_wdata),
        .o_imem_valid(o_imem_valid), .o_pc_enable(o_pc_enable), .o_pc_halt(o_pc_halt),
        .o_pc_stall(o_pc_stall), .o_pc_clear(o_pc_clear), .o_pc_sel(o_pc_sel),
        .o_pc_target(o_pc_target), .o_loaded(o_loaded), .o_done(o_done), .o_state(o_state),
        .o_cycle_count(o_cycle_count)
    );

    always #5 clk = ~clk;

    // Instruction memory and PC register models
    always @(posedge clk) begin
        if (o_imem_we) begin
            mem[o_imem_waddr[5:0]] <= o_imem_wdata;
            write_count <= write_count + 1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= '0;
        else if (o_pc_clear) pc <= '0;
        else if (o_pc_enable) pc <= o_pc_sel ? o_pc_target : pc + 32'd1;
    end

    assign i_halt_signal = (mem[pc[5:0]] === HALT);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] w);
        i_load_valid = 1'b1;
        i_load_data  = w;
        tick();
        i_load_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", o_state); end
        checks++; if ({o_imem_we, o_imem_valid, o_pc_enable, o_pc_halt, o_pc_stall, o_pc_clear, o_pc_sel, o_loaded, o_done} !== 9'b0) begin
            errors++; $display("FAIL reset_outputs: got %b want 0", {o_imem_we, o_imem_valid, o_pc_enable, o_pc_halt, o_pc_stall, o_pc_clear, o_pc_sel, o_loaded, o_done}); end
        checks++; if (o_cycle_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", o_cycle_count); end
        @(negedge clk); rst_n = 1'b1;
        tick();
        i_run = 1'b1; tick(); i_run = 1'b0; tick();
        checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL run_unloaded: got %0d want 0", o_state); end
    endtask

    task automatic test_load();
        int wc0;
        i_load_start = 1'b1; tick(); i_load_start = 1'b0;
        checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL load_enter: got %0d want 1", o_state); end
        wc0 = write_count;
        load_word(32'h11); load_word(32'h22); load_word(32'h33); load_word(HALT);
        checks++; if (o_loaded !== 1'b1 || o_state !== 3'd0) begin errors++; $display("FAIL load_end: got loaded=%b state=%0d want 1/0", o_loaded, o_state); end
        load_word(32'h55); tick(); tick();
        checks++; if (write_count - wc0 !== 4) begin errors++; $display("FAIL load_writes: got %0d want 4", write_count - wc0); end
        checks++; if (mem[0] !== 32'h11 || mem[1] !== 32'h22 || mem[2] !== 32'h33 || mem[3] !== HALT) begin
            errors++; $display("FAIL load_data: got %h %h %h %h", mem[0], mem[1], mem[2], mem[3]); end
    endtask

    task automatic test_run_continuous();
        int halt_at, done_at, drain_n;
        halt_at = -1; done_at = -1; drain_n = 0;
        i_mode_step = 1'b0; i_run = 1'b1; tick(); i_run = 1'b0;
        checks++; if (o_state !== 3'd2 || o_pc_enable !== 1'b1 || o_imem_valid !== 1'b1) begin
            errors++; $display("FAIL run_enter: got state=%0d en=%b valid=%b want 2/1/1", o_state, o_pc_enable, o_imem_valid); end
        for (int n = 0; n < 40; n++) begin
            if (halt_at < 0 && o_state == 3'd2 && i_halt_signal) begin
                halt_at = n;
                checks++; if (o_pc_halt !== 1'b1 || o_pc_enable !== 1'b0) begin
                    errors++; $display("FAIL halt_hold: got halt=%b en=%b want 1/0", o_pc_halt, o_pc_enable); end
            end
            if (o_state == 3'd5) drain_n++;
            if (o_done) begin done_at = n; break; end
            tick();
        end
        checks++; if (done_at < 0) begin errors++; $display("FAIL run_timeout: got no done want done"); end
        checks++; if (halt_at !== 3 || done_at !== 8) begin errors++; $display("FAIL run_timing: got halt=%0d done=%0d want 3/8", halt_at, done_at); end
        checks++; if (drain_n !== 4) begin errors++; $display("FAIL drain_len: got %0d want 4", drain_n); end
        checks++; if (pc !== 32'd3 || o_cycle_count !== 32'd3 || o_state !== 3'd6) begin
            errors++; $display("FAIL run_final: got pc=%0d cnt=%0d state=%0d want 3/3/6", pc, o_cycle_count, o_state); end
    endtask

    task automatic test_clear();
        i_clear = 1'b1; #1;
        checks++; if (o_pc_clear !== 1'b1) begin errors++; $display("FAIL clear_pulse: got %b want 1", o_pc_clear); end
        tick(); i_clear = 1'b0;
        checks++; if (o_state !== 3'd0 || o_done !== 1'b0 || o_cycle_count !== 32'd0 || o_pc_clear !== 1'b0) begin
            errors++; $display("FAIL clear_state: got state=%0d done=%b cnt=%0d clr=%b want 0/0/0/0", o_state, o_done, o_cycle_count, o_pc_clear); end
        checks++; if (o_loaded !== 1'b1 || pc !== 32'd0) begin errors++; $display("FAIL clear_keep: got loaded=%b pc=%0d want 1/0", o_loaded, pc); end
    endtask

    task automatic test_step();
        int adv;
        i_mode_step = 1'b1; i_run = 1'b1; tick(); i_run = 1'b0; i_mode_step = 1'b0;
        checks++; if (o_state !== 3'd3) begin errors++; $display("FAIL step_enter: got %0d want 3", o_state); end
        for (int s = 0; s < 3; s++) begin
            adv = 0;
            i_step = 1'b1;
            for (int c = 0; c < 5; c++) begin if (o_pc_enable) adv++; tick(); end
            i_step = 1'b0;
            for (int c = 0; c < 5; c++) begin if (o_pc_enable) adv++; tick(); end
            checks++; if (adv !== 1 || o_state !== 3'd3 || pc !== 32'(s + 1)) begin
                errors++; $display("FAIL step_%0d: got adv=%0d state=%0d pc=%0d want 1/3/%0d", s, adv, o_state, pc, s + 1); end
        end
        i_step = 1'b1;
        for (int c = 0; c < 30 && o_state != 3'd6; c++) tick();
        i_step = 1'b0;
        checks++; if (o_state !== 3'd6 || pc !== 32'd3 || o_cycle_count !== 32'd3) begin
            errors++; $display("FAIL step_halt: got state=%0d pc=%0d cnt=%0d want 6/3/3", o_state, pc, o_cycle_count); end
        i_clear = 1'b1; tick(); i_clear = 1'b0;
    endtask

    task automatic test_stall_branch();
        logic [31:0] pc0;
        i_load_start = 1'b1; tick(); i_load_start = 1'b0;
        for (int i = 0; i < 17; i++) load_word(32'h1);
        load_word(HALT); tick(); tick();
        checks++; if (mem[17] !== HALT || o_loaded !== 1'b1) begin errors++; $display("FAIL prog2_load: got %h loaded=%b", mem[17], o_loaded); end
        i_run = 1'b1; tick(); i_run = 1'b0; tick();
        i_stall = 1'b1; i_branch_taken = 1'b1; i_branch_target = 32'h10; #1;
        checks++; if (o_pc_stall !== 1'b1 || o_pc_sel !== 1'b0 || o_pc_enable !== 1'b0 || o_pc_target !== 32'h10) begin
            errors++; $display("FAIL stall_ctrl: got stall=%b sel=%b en=%b tgt=%h want 1/0/0/10", o_pc_stall, o_pc_sel, o_pc_enable, o_pc_target); end
        pc0 = pc;
        checks++; if (pc0 !== 32'd1 || o_cycle_count !== 32'd1) begin errors++; $display("FAIL stall_pre: got pc=%0d cnt=%0d want 1/1", pc0, o_cycle_count); end
        tick(); tick();
        checks++; if (pc !== 32'd1 || o_cycle_count !== 32'd1) begin errors++; $display("FAIL stall_hold: got pc=%0d cnt=%0d want 1/1", pc, o_cycle_count); end
        i_stall = 1'b0; #1;
        checks++; if (o_pc_sel !== 1'b1 || o_pc_enable !== 1'b1 || o_pc_target !== 32'h10) begin
            errors++; $display("FAIL branch_ctrl: got sel=%b en=%b tgt=%h want 1/1/10", o_pc_sel, o_pc_enable, o_pc_target); end
        tick(); i_branch_taken = 1'b0;
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL branch_pc: got %h want 10", pc); end
        for (int c = 0; c < 30 && o_state != 3'd6; c++) tick();
        checks++; if (o_state !== 3'd6 || pc !== 32'd17 || o_cycle_count !== 32'd3) begin
            errors++; $display("FAIL branch_final: got state=%0d pc=%0d cnt=%0d want 6/17/3", o_state, pc, o_cycle_count); end
        i_clear = 1'b1; tick(); i_clear = 1'b0;
    endtask

    task automatic test_load_full();
        int wc0;
        i_load_start = 1'b1; i_run = 1'b1; tick(); i_load_start = 1'b0; i_run = 1'b0;
        checks++; if (o_state !== 3'd1 || o_loaded !== 1'b0) begin errors++; $display("FAIL load_priority: got state=%0d loaded=%b want 1/0", o_state, o_loaded); end
        wc0 = write_count;
        for (int i = 0; i < 66; i++) load_word(32'(i + 100));
        tick(); tick();
        checks++; if (write_count - wc0 !== 64 || mem[63] !== 32'd163) begin
            errors++; $display("FAIL load_full: got writes=%0d last=%0d want 64/163", write_count - wc0, mem[63]); end
        checks++; if (o_loaded !== 1'b1 || o_state !== 3'd0) begin errors++; $display("FAIL load_full_end: got loaded=%b state=%0d want 1/0", o_loaded, o_state); end
    endtask

    task automatic test_reset_midload();
        i_load_start = 1'b1; tick(); i_load_start = 1'b0;
        load_word(32'h7); load_word(32'h8);
        #2; rst_n = 1'b0; #1;
        checks++; if (o_loaded !== 1'b0 || o_state !== 3'd0 || o_imem_we !== 1'b0) begin
            errors++; $display("FAIL midload_reset: got loaded=%b state=%0d we=%b want 0/0/0", o_loaded, o_state, o_imem_we); end
        @(negedge clk); rst_n = 1'b1;
        tick();
        i_load_start = 1'b1; tick(); i_load_start = 1'b0;
        load_word(32'h9);
        checks++; if (o_imem_we !== 1'b1 || o_imem_waddr !== 32'd0 || o_imem_wdata !== 32'h9) begin
            errors++; $display("FAIL reload_addr: got we=%b addr=%0d data=%h want 1/0/9", o_imem_we, o_imem_waddr, o_imem_wdata); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_run_continuous();
        test_clear();
        test_step();
        test_stall_branch();
        test_load_full();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
